// File: rtl/cnt_mod_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_pkg
//  Description : Shared helpers for the modulo counter chain: per-digit
//                terminal value and parameter legality check.
//  Revision    : 1.0  initial release
// ============================================================================
package cnt_pkg;

    // Terminal value of a single digit for the given counting direction.
    function automatic int unsigned digit_term(input int unsigned mod, input logic up);
        return up ? (mod - 1) : 0;
    endfunction

    // Legal when at least one digit exists, the modulus is at least 2 and
    // every digit value below the modulus fits in DW bits.
    function automatic bit params_ok(input int digits, input int mod, input int dw);
        return (digits >= 1) && (mod >= 2) && (dw >= 1) && (dw < 31) &&
               ((64'd1 << dw) >= 64'(mod));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_mod_chain_if.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_mod_chain_if
//  Description : Control, data and status bundle of one counter chain.
//  Revision    : 1.0  initial release
// ============================================================================
interface cnt_mod_chain_if #(
    parameter int DIGITS = 2,
    parameter int DW     = 4
);
    logic                   EN;
    logic                   LOAD;
    logic                   UP;
    logic                   CIN;
    logic [DIGITS*DW-1:0]   DATA;
    logic [DIGITS*DW-1:0]   DOUT;
    logic                   COUT;
    logic                   WRAP;
    logic                   LDERR;

    modport master (
        output EN, LOAD, UP, CIN, DATA,
        input  DOUT, COUT, WRAP, LDERR
    );

    modport slave (
        input  EN, LOAD, UP, CIN, DATA,
        output DOUT, COUT, WRAP, LDERR
    );
endinterface
`default_nettype wire

// File: rtl/cnt_mod_chain_digit.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_digit
//  Description : One modulo-MOD digit cell with up/down step and clamped load.
//  Revision    : 1.0  initial release
// ============================================================================
module cnt_digit
    import cnt_pkg::*;
#(
    parameter int MOD = 10,
    parameter int DW  = 4
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    input  wire logic           step,
    input  wire logic           up,
    input  wire logic           load,
    input  wire logic [DW-1:0]  din,
    output logic      [DW-1:0]  q,
    output logic                term,
    output logic                bad
);

    localparam logic [DW-1:0] c_max = DW'(MOD - 1);
    localparam logic [DW:0]   c_mod = (DW + 1)'(MOD);

    logic [DW-1:0] r_q;
    logic [DW-1:0] w_next;
    logic [DW-1:0] w_tval;

    assign bad    = ({1'b0, din} >= c_mod);
    assign w_tval = DW'(digit_term(MOD, up));
    assign term   = (r_q == w_tval);
    assign q      = r_q;

    // Out-of-range load digits are forced to zero so q never leaves 0..MOD-1.
    always_comb begin
        w_next = r_q;
        if (load) begin
            w_next = bad ? '0 : din;
        end else if (step) begin
            if (up) begin
                w_next = (r_q == c_max) ? '0 : r_q + DW'(1);
            end else begin
                w_next = (r_q == '0) ? c_max : r_q - DW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnt_mod_chain.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_mod_chain
//  Description : DIGITS-digit modulo-MOD up/down counter with lookahead carry,
//                cascade carry, wrap pulse and load range-error pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module cnt_mod_chain
    import cnt_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int MOD    = 10,
    parameter int DW     = 4
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    cnt_mod_chain_if.slave  bus
);

    localparam bit c_params_ok = params_ok(DIGITS, MOD, DW);

    generate
        if (!c_params_ok) begin : g_param_check
            $error("cnt_mod_chain: illegal DIGITS/MOD/DW combination");
        end
    endgenerate

    logic [DIGITS-1:0]    w_term;
    logic [DIGITS-1:0]    w_bad;
    logic [DIGITS-1:0]    w_dstep;
    logic [DIGITS*DW-1:0] w_dout;
    logic                 w_load;
    logic                 w_step;
    logic                 w_tc;
    logic                 r_wrap;
    logic                 r_lderr;

    assign w_load = bus.EN & ~bus.LOAD;
    assign w_step = bus.EN &  bus.LOAD & bus.CIN;
    assign w_tc   = &w_term;

    // Parallel lookahead: each digit steps when every lower digit is terminal.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign w_dstep[gi] = w_step;
            end else begin : g_upper
                assign w_dstep[gi] = w_step & (&w_term[gi-1:0]);
            end

            cnt_digit #(
                .MOD (MOD),
                .DW  (DW)
            ) u_digit (
                .CLK  (CLK),
                .RST  (RST),
                .step (w_dstep[gi]),
                .up   (bus.UP),
                .load (w_load),
                .din  (bus.DATA[gi*DW +: DW]),
                .q    (w_dout[gi*DW +: DW]),
                .term (w_term[gi]),
                .bad  (w_bad[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wrap  <= 1'b0;
            r_lderr <= 1'b0;
        end else begin
            r_wrap  <= w_step & w_tc;
            r_lderr <= w_load & (|w_bad);
        end
    end

    assign bus.DOUT  = w_dout;
    assign bus.COUT  = w_step & w_tc;
    assign bus.WRAP  = r_wrap;
    assign bus.LDERR = r_lderr;

endmodule
`default_nettype wire

// File: tb/tb_cnt_mod_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt_mod_chain
//  Description : Self-checking bench: 2-digit decimal chain against an integer
//                model, plus a cascaded pair of base-6 single-digit stages.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cnt_mod_chain;

    localparam int DIGITS = 2;
    localparam int MOD    = 10;
    localparam int DW     = 4;
    localparam int TOT    = MOD ** DIGITS;
    localparam int CMOD   = 6;
    localparam int CDW    = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    cnt_mod_chain_if #(.DIGITS(DIGITS), .DW(DW))  bus ();
    cnt_mod_chain_if #(.DIGITS(1),      .DW(CDW)) clo ();
    cnt_mod_chain_if #(.DIGITS(1),      .DW(CDW)) chi ();

    cnt_mod_chain #(.DIGITS(DIGITS), .MOD(MOD), .DW(DW)) u_dut (
        .CLK (CLK), .RST (RST), .bus (bus.slave)
    );
    cnt_mod_chain #(.DIGITS(1), .MOD(CMOD), .DW(CDW)) u_lo (
        .CLK (CLK), .RST (RST), .bus (clo.slave)
    );
    cnt_mod_chain #(.DIGITS(1), .MOD(CMOD), .DW(CDW)) u_hi (
        .CLK (CLK), .RST (RST), .bus (chi.slave)
    );

    assign chi.CIN = clo.COUT;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the whole chain as a single integer 0..TOT-1.
    int m_n     = 0;
    bit m_wrap  = 1'b0;
    bit m_lderr = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s observed=%0h required=%0h at %0t", tag, obs, req, $time);
        end
    endtask

    function automatic logic [DIGITS*DW-1:0] to_digits(input int n);
        logic [DIGITS*DW-1:0] v;
        int r;
        v = '0;
        r = n;
        for (int i = 0; i < DIGITS; i++) begin
            v[i*DW +: DW] = DW'(r % MOD);
            r = r / MOD;
        end
        return v;
    endfunction

    function automatic bit model_tc(input bit up);
        return up ? (m_n == TOT - 1) : (m_n == 0);
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit en, input bit ld, input bit up, input bit cin,
                              input logic [DIGITS*DW-1:0] data);
        int acc, mult, d;
        bit bad;
        if (en && !ld) begin
            acc = 0; mult = 1; bad = 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                d = int'(data[i*DW +: DW]);
                if (d >= MOD) begin
                    d = 0;
                    bad = 1'b1;
                end
                acc += d * mult;
                mult *= MOD;
            end
            m_n = acc; m_wrap = 1'b0; m_lderr = bad;
        end else if (en && cin) begin
            m_wrap  = model_tc(up);
            m_lderr = 1'b0;
            m_n     = up ? (m_n + 1) % TOT : (m_n + TOT - 1) % TOT;
        end else begin
            m_wrap = 1'b0; m_lderr = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".dout"},  32'(bus.DOUT),  32'(to_digits(m_n)));
        check_val({tag, ".wrap"},  32'(bus.WRAP),  32'(m_wrap));
        check_val({tag, ".lderr"}, 32'(bus.LDERR), 32'(m_lderr));
    endtask

    // Called just after a falling edge: drive, check COUT, clock, check state.
    task automatic cycle(input string tag, input bit en, input bit ld, input bit up,
                         input bit cin, input logic [DIGITS*DW-1:0] data);
        bus.EN = en; bus.LOAD = ld; bus.UP = up; bus.CIN = cin; bus.DATA = data;
        #1;
        check_val({tag, ".cout"}, 32'(bus.COUT), 32'(en & ld & cin & model_tc(up)));
        @(posedge CLK);
        model_edge(en, ld, up, cin, data);
        @(negedge CLK);
        check_outputs(tag);
    endtask

    initial begin
        int k;
        bit r_en, r_ld, r_up, r_cin;
        logic [DIGITS*DW-1:0] r_data;

        bus.EN = 1'b0; bus.LOAD = 1'b1; bus.UP = 1'b1; bus.CIN = 1'b0; bus.DATA = '0;
        clo.EN = 1'b0; clo.LOAD = 1'b1; clo.UP = 1'b1; clo.CIN = 1'b1; clo.DATA = '0;
        chi.EN = 1'b0; chi.LOAD = 1'b1; chi.UP = 1'b1;                 chi.DATA = '0;

        repeat (2) @(negedge CLK);
        check_outputs("reset");
        RST = 1'b1;

        // Full up-count 00..99..00 with one wrap pulse.
        for (int i = 0; i < 100; i++) cycle("up", 1'b1, 1'b1, 1'b1, 1'b1, '0);
        cycle("up_after", 1'b1, 1'b1, 1'b1, 1'b1, '0);

        // Down-count with borrow, then wrap downward.
        cycle("ld10",  1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
        cycle("dn1",   1'b1, 1'b1, 1'b0, 1'b1, '0);
        cycle("dn2",   1'b1, 1'b1, 1'b0, 1'b1, '0);
        cycle("ld00",  1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle("dnwrap",1'b1, 1'b1, 1'b0, 1'b1, '0);
        cycle("dn_after", 1'b1, 1'b1, 1'b0, 1'b1, '0);

        // Range-checked load.
        cycle("ldA7", 1'b1, 1'b0, 1'b1, 1'b1, 8'hA7);
        cycle("ld35", 1'b1, 1'b0, 1'b1, 1'b1, 8'h35);
        cycle("ldF9", 1'b1, 1'b0, 1'b1, 1'b1, 8'hF9);

        // Enable gating and load-beats-terminal.
        cycle("ld42", 1'b1, 1'b0, 1'b1, 1'b1, 8'h42);
        for (int i = 0; i < 5; i++) cycle("cin0", 1'b1, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle("en0",  1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        cycle("ld99",  1'b1, 1'b0, 1'b1, 1'b1, 8'h99);
        cycle("ldtc",  1'b1, 1'b0, 1'b1, 1'b1, 8'h12);

        // Asynchronous reset while a WRAP pulse is showing.
        cycle("ld99b", 1'b1, 1'b0, 1'b1, 1'b1, 8'h99);
        cycle("wrap",  1'b1, 1'b1, 1'b1, 1'b1, '0);
        RST = 1'b0;
        #1;
        m_n = 0; m_wrap = 1'b0; m_lderr = 1'b0;
        check_outputs("arst_wrap");
        #1 RST = 1'b1;
        // And while an LDERR pulse is showing.
        cycle("ldbad", 1'b1, 1'b0, 1'b1, 1'b1, 8'h5C);
        RST = 1'b0;
        #1;
        m_n = 0; m_wrap = 1'b0; m_lderr = 1'b0;
        check_outputs("arst_lderr");
        #1 RST = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r_en   = ($urandom_range(0, 7) != 0);
            r_ld   = ($urandom_range(0, 5) != 0);
            r_up   = ($urandom_range(0, 3) != 0);
            r_cin  = ($urandom_range(0, 4) != 0);
            r_data = DIGITS*DW'($urandom);
            if ($urandom_range(0, 3) == 0) r_data = to_digits(TOT - 1);
            cycle("rand", r_en, r_ld, r_up, r_cin, r_data);
        end

        // Cascaded base-6 pair: lower COUT drives upper CIN.
        clo.EN = 1'b1; chi.EN = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            check_val("csc.cout", 32'(clo.COUT), 32'(k % CMOD == CMOD - 1));
            @(posedge CLK);
            k = (k + 1) % (CMOD * CMOD);
            @(negedge CLK);
            check_val("csc.lo", 32'(clo.DOUT), 32'(k % CMOD));
            check_val("csc.hi", 32'(chi.DOUT), 32'(k / CMOD));
            check_val("csc.wrap", 32'(chi.WRAP), 32'(k == 0));
        end
        clo.UP = 1'b0; chi.UP = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            k = (k + CMOD * CMOD - 1) % (CMOD * CMOD);
            @(negedge CLK);
            check_val("csc.dn_lo", 32'(clo.DOUT), 32'(k % CMOD));
            check_val("csc.dn_hi", 32'(chi.DOUT), 32'(k / CMOD));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
